board_writer: RTL and testbench
===============================

BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 The block SHALL have parameter BOARD_N, default 10, meaning the board is BOARD_N x BOARD_N cells, legal range 2..11 so that BOARD_N*BOARD_N <= 128.
REQ-002 The block SHALL have parameter COORD_W, default 4, meaning bits per row or column coordinate.
REQ-003 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i0  input  1  asynchronous level input; a rising edge enters bit '0'.
REQ-006 i1  input  1  asynchronous level input; a rising edge enters bit '1'.
REQ-007 q_b  input  2  board_memory port-B read data.
REQ-008 addr_b  output  7  board_memory port-B address, cell index row*BOARD_N+col.
REQ-009 data_b  output  2  port-B write data: 00 empty, 01 player 1, 10 player 2.
REQ-010 we_b  output  1  port-B write enable, single-cycle pulse.
REQ-011 turn  output  1  current player: 0 = player 1, 1 = player 2.
REQ-012 move_done  output  1  one-cycle pulse on each accepted move.
REQ-013 move_err  output  1  one-cycle pulse on each rejected move.
REQ-014 board_full  output  1  high once all BOARD_N*BOARD_N cells are occupied.

Function
REQ-015 i0 and i1 SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-016 A detected edge on exactly one input SHALL shift the corresponding bit, MSB first, into a 2*COORD_W-bit shift register (row in the upper half, column in the lower half).
REQ-017 Edges detected on both inputs in the same cycle SHALL be ignored.
REQ-018 The FSM states SHALL be CLEAR, COLLECT, READ, CHECK, WRITE, DONE.
REQ-019 In COLLECT, when the bit counter reaches 2*COORD_W, the FSM SHALL go to READ on the next cycle.
REQ-020 If row >= BOARD_N or col >= BOARD_N, the FSM SHALL pulse move_err, clear the bit counter, return to COLLECT, and issue no memory access.
REQ-021 READ SHALL drive addr_b = row*BOARD_N+col with we_b low.
REQ-022 CHECK SHALL sample q_b exactly one cycle after READ (board_memory read latency is 1 cycle).
REQ-023 If the sampled q_b != 00, the block SHALL pulse move_err and return to COLLECT.
REQ-024 If the sampled q_b == 00, the block SHALL enter WRITE.
REQ-025 WRITE SHALL assert we_b for exactly one cycle, with data_b = {turn, ~turn} and the same addr_b.
REQ-026 On the cycle after WRITE, the block SHALL pulse move_done, toggle turn, increment the 7-bit move counter, and return to COLLECT.
REQ-027 Edges arriving outside COLLECT SHALL be discarded, not queued.
REQ-028 When the move counter equals BOARD_N*BOARD_N, board_full SHALL be set and the FSM SHALL enter DONE.
REQ-029 DONE SHALL ignore all inputs until reset.
REQ-030 Move validation latency: move_done or move_err SHALL assert within 4 cycles of the final accepted bit edge.
REQ-031 we_b SHALL never be high outside WRITE or CLEAR.

Reset
REQ-032 On reset, outputs SHALL be: addr_b=0, data_b=00, we_b=0, turn=0, move_done=0, move_err=0, board_full=0.
REQ-033 On reset, the bit counter, shift register, move counter and synchronizers SHALL be cleared.
REQ-034 Reset asserted mid-move, including during WRITE, SHALL abort the move in the same edge; no further we_b pulse SHALL follow.
REQ-035 After reset, the FSM SHALL enter CLEAR when BOARD_CLEAR_EN is defined, otherwise COLLECT.

Configuration
REQ-036 Macro BOARD_CLEAR_EN defined: CLEAR SHALL write 00 to addresses 0..BOARD_N*BOARD_N-1, one per cycle with we_b high, then enter COLLECT.
REQ-037 During CLEAR, i0/i1 edges SHALL be discarded.
REQ-038 Macro BOARD_CLEAR_EN undefined: the CLEAR state SHALL be absent, and board contents SHALL be the memory initialisation values.

Verification
REQ-039 Bits 0001 0010 (row 1, col 2), empty cell -> addr_b=12, we_b one cycle, data_b=01, move_done pulse, turn=1.
REQ-040 Repeat the same move -> read of addr 12 returns 01, move_err pulse, no we_b, turn stays 1.
REQ-041 Row 1010 (10) with any col -> move_err within 4 cycles, no addr_b read or write.
REQ-042 i0 and i1 rising in the same cycle -> bit counter unchanged.
REQ-043 Reset asserted 3 bits into a move -> counter cleared; 8 fresh bits form a new move.
REQ-044 With BOARD_CLEAR_EN defined, reset -> 100 consecutive we_b cycles, addr_b 0..99, data_b=00; then 100 legal moves -> board_full=1 and further inputs ignored.

Source files
------------

// File: rtl/board_writer.sv
// board_writer: assembles serial row/col bits from two async inputs, checks the
// target cell in board_memory and marks it for the current player. Optional macro BOARD_CLEAR_EN.
module board_writer #(
  parameter int BOARD_N = 10,
  parameter int COORD_W = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       i0,
  input  logic       i1,
  input  logic [1:0] q_b,
  output logic [6:0] addr_b,
  output logic [1:0] data_b,
  output logic       we_b,
  output logic       turn,
  output logic       move_done,
  output logic       move_err,
  output logic       board_full
);

  localparam int SHIFT_W = 2 * COORD_W;
  localparam int CNT_W = $clog2(SHIFT_W + 1);
  localparam logic [6:0] CELLS = 7'(BOARD_N * BOARD_N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SHIFT_W - 1);

`ifdef BOARD_CLEAR_EN
  typedef enum logic [2:0] {CLEAR, COLLECT, READ, CHECK, WRITE, DONE} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [2:0] {COLLECT, READ, CHECK, WRITE, DONE} state_t;
  localparam state_t RESET_STATE = COLLECT;
`endif

  state_t state, state_next;

  logic               i0_meta, i0_sync, i0_prev;
  logic               i1_meta, i1_sync, i1_prev;
  logic               edge0, edge1, bit_edge, last_bit, in_range;
  logic [SHIFT_W-1:0] shreg, shift_next;
  logic [COORD_W-1:0] row_next, col_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [6:0]         addr_q, cell_addr, move_cnt, move_cnt_inc;

  assign edge0 = i0_sync & ~i0_prev;
  assign edge1 = i1_sync & ~i1_prev;

  // The final bit is judged on the value it produces, so the move is decided
  // in the same edge that shifts it in rather than one cycle later.
  assign bit_edge     = (state == COLLECT) && (edge0 ^ edge1);
  assign shift_next   = {shreg[SHIFT_W-2:0], edge1};
  assign row_next     = shift_next[SHIFT_W-1:COORD_W];
  assign col_next     = shift_next[COORD_W-1:0];
  assign last_bit     = bit_edge && (bit_cnt == LAST_BIT);
  assign in_range     = (int'(row_next) < BOARD_N) && (int'(col_next) < BOARD_N);
  assign cell_addr    = 7'(row_next) * 7'(BOARD_N) + 7'(col_next);
  assign move_cnt_inc = move_cnt + 7'd1;

  assign addr_b = addr_q;
  assign we_b   = !reset && ((state == WRITE)
`ifdef BOARD_CLEAR_EN
                             || (state == CLEAR)
`endif
                            );
  assign data_b = (!reset && state == WRITE) ? {turn, ~turn} : 2'b00;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef BOARD_CLEAR_EN
      CLEAR:   if (addr_q == CELLS - 7'd1) state_next = COLLECT;
`endif
      COLLECT: if (last_bit && in_range) state_next = READ;
      READ:    state_next = CHECK;
      CHECK:   state_next = (q_b == 2'b00) ? WRITE : COLLECT;
      WRITE:   state_next = (move_cnt_inc == CELLS) ? DONE : COLLECT;
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
  end

  // Datapath: synchronizers, bit collection, address/move bookkeeping and result pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      i0_meta    <= 1'b0;
      i0_sync    <= 1'b0;
      i0_prev    <= 1'b0;
      i1_meta    <= 1'b0;
      i1_sync    <= 1'b0;
      i1_prev    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      addr_q     <= 7'd0;
      move_cnt   <= 7'd0;
      turn       <= 1'b0;
      move_done  <= 1'b0;
      move_err   <= 1'b0;
      board_full <= 1'b0;
    end else begin
      i0_meta   <= i0;
      i0_sync   <= i0_meta;
      i0_prev   <= i0_sync;
      i1_meta   <= i1;
      i1_sync   <= i1_meta;
      i1_prev   <= i1_sync;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      case (state)
`ifdef BOARD_CLEAR_EN
        CLEAR: addr_q <= (addr_q == CELLS - 7'd1) ? 7'd0 : addr_q + 7'd1;
`endif
        COLLECT: begin
          if (bit_edge) begin
            shreg <= shift_next;
            if (last_bit) begin
              bit_cnt <= '0;
              if (in_range) addr_q <= cell_addr;
              else           move_err <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        CHECK: if (q_b != 2'b00) move_err <= 1'b1;
        WRITE: begin
          move_done <= 1'b1;
          turn      <= ~turn;
          move_cnt  <= move_cnt_inc;
          if (move_cnt_inc == CELLS) board_full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// tb_board_writer: directed self-checking bench for board_writer with a 1-cycle-latency
// board_memory model on port B. Covers the BOARD_CLEAR_EN build when that macro is defined.
module tb_board_writer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       i0 = 1'b0;
  logic       i1 = 1'b0;
  logic [1:0] q_b = 2'b00;
  logic [6:0] addr_b;
  logic [1:0] data_b;
  logic       we_b, turn, move_done, move_err, board_full;

  logic       mem_wipe = 1'b1;
  logic [1:0] mem [0:127];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int evt_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int we_cnt = 0;
  int we_run = 0;
  int we_run_max = 0;
  logic [6:0] last_we_addr = 7'd0;
  logic [1:0] last_we_data = 2'b00;

  board_writer #(.BOARD_N(10), .COORD_W(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .i0        (i0),
    .i1        (i1),
    .q_b       (q_b),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .we_b      (we_b),
    .turn      (turn),
    .move_done (move_done),
    .move_err  (move_err),
    .board_full(board_full)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (mem_wipe) begin
      for (int i = 0; i < 128; i++) mem[i] <= 2'b00;
    end else if (we_b) begin
      mem[addr_b] <= data_b;
    end
    q_b <= mem[addr_b];
  end

  // Event monitor: counts result pulses and write cycles, remembers the last write.
  always @(negedge CLOCK_50) begin
    if (move_done) begin
      done_cnt <= done_cnt + 1;
      evt_cyc  <= cyc;
    end
    if (move_err) begin
      err_cnt <= err_cnt + 1;
      evt_cyc <= cyc;
    end
    if (we_b) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= addr_b;
      last_we_data <= data_b;
      we_run       <= we_run + 1;
      if (we_run + 1 > we_run_max) we_run_max <= we_run + 1;
    end else begin
      we_run <= 0;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic b);
    @(negedge CLOCK_50);
    rise_cyc = cyc;
    if (b) i1 = 1'b1;
    else   i0 = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    i0 = 1'b0;
    i1 = 1'b0;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic applyBoth();
    @(negedge CLOCK_50);
    i0 = 1'b1;
    i1 = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    i0 = 1'b0;
    i1 = 1'b0;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic sendMove(input int row, input int col);
    logic [7:0] bits;
    bits = {4'(row), 4'(col)};
    for (int i = 7; i >= 0; i--) applyStimulus(bits[i]);
  endtask

  task automatic holdReset();
    @(negedge CLOCK_50);
    reset    = 1'b1;
    mem_wipe = 1'b1;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic releaseReset();
    int good;
    reset    = 1'b0;
    mem_wipe = 1'b0;
    good     = 0;
`ifdef BOARD_CLEAR_EN
    for (int i = 0; i < 100; i++) begin
      #1;
      if (we_b && data_b == 2'b00 && addr_b == 7'(i)) good++;
      @(negedge CLOCK_50);
    end
    #1;
    checkOutput("clear_cycles", good, 100);
    checkOutput("clear_end_we", we_b, 0);
`endif
    @(negedge CLOCK_50);
  endtask

  initial begin
    int d_done, d_err, d_we;
    logic seen;

    $display("[TB] start");
    holdReset();
    checkOutput("rst_addr", addr_b, 0);
    checkOutput("rst_data", data_b, 0);
    checkOutput("rst_we", we_b, 0);
    checkOutput("rst_turn", turn, 0);
    checkOutput("rst_done", move_done, 0);
    checkOutput("rst_err", move_err, 0);
    checkOutput("rst_full", board_full, 0);
    releaseReset();

    // Row 1, col 2 on an empty board.
    d_done = done_cnt; d_err = err_cnt; d_we = we_cnt;
    sendMove(1, 2);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("m1_done", done_cnt - d_done, 1);
    checkOutput("m1_err", err_cnt - d_err, 0);
    checkOutput("m1_we", we_cnt - d_we, 1);
    checkOutput("m1_addr", last_we_addr, 12);
    checkOutput("m1_data", last_we_data, 1);
    checkOutput("m1_turn", turn, 1);
    checkOutput("m1_lat", (evt_cyc - rise_cyc) <= 7, 1);

    // Same cell again is occupied.
    d_done = done_cnt; d_err = err_cnt; d_we = we_cnt;
    sendMove(1, 2);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("occ_err", err_cnt - d_err, 1);
    checkOutput("occ_done", done_cnt - d_done, 0);
    checkOutput("occ_we", we_cnt - d_we, 0);
    checkOutput("occ_addr", addr_b, 12);
    checkOutput("occ_turn", turn, 1);
    checkOutput("occ_lat", (evt_cyc - rise_cyc) <= 7, 1);

    // Row 10 is off the board: no memory access at all.
    d_done = done_cnt; d_err = err_cnt; d_we = we_cnt;
    sendMove(10, 3);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("row_err", err_cnt - d_err, 1);
    checkOutput("row_we", we_cnt - d_we, 0);
    checkOutput("row_addr", addr_b, 12);
    checkOutput("row_lat", (evt_cyc - rise_cyc) <= 4, 1);

    d_err = err_cnt; d_we = we_cnt;
    sendMove(3, 11);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("col_err", err_cnt - d_err, 1);
    checkOutput("col_we", we_cnt - d_we, 0);
    checkOutput("col_addr", addr_b, 12);

    // Simultaneous edges must not count as a bit; the following move stays aligned.
    d_done = done_cnt; d_err = err_cnt;
    applyBoth();
    sendMove(2, 3);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("both_done", done_cnt - d_done, 1);
    checkOutput("both_err", err_cnt - d_err, 0);
    checkOutput("both_addr", last_we_addr, 23);
    checkOutput("both_data", last_we_data, 2);
    checkOutput("both_turn", turn, 0);

    // First move sets turn; then reset three bits into a move.
    sendMove(5, 5);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("pre_turn", turn, 1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    holdReset();
    releaseReset();
    checkOutput("mid_turn", turn, 0);
    d_done = done_cnt; d_err = err_cnt;
    sendMove(4, 5);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("mid_done", done_cnt - d_done, 1);
    checkOutput("mid_err", err_cnt - d_err, 0);
    checkOutput("mid_addr", last_we_addr, 45);
    checkOutput("mid_data", last_we_data, 1);
    checkOutput("mid_turn2", turn, 1);

    // Reset landing on the WRITE cycle aborts the move.
    sendMove(0, 0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLOCK_50);
      if (we_b) seen = 1'b1;
    end
    reset  = 1'b1;
    d_done = done_cnt;
    checkOutput("abort_seen", seen, 1);
    holdReset();
    releaseReset();
    d_we = we_cnt;
    repeat (12) @(negedge CLOCK_50);
    checkOutput("abort_we", we_cnt - d_we, 0);
    checkOutput("abort_done", done_cnt - d_done, 0);
    checkOutput("abort_turn", turn, 0);

    // Fill the whole board.
    d_done = done_cnt; d_err = err_cnt;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        sendMove(r, c);
        repeat (4) @(negedge CLOCK_50);
        if (r == 9 && c == 8) checkOutput("fill_not_full", board_full, 0);
      end
    end
    repeat (2) @(negedge CLOCK_50);
    checkOutput("fill_done", done_cnt - d_done, 100);
    checkOutput("fill_err", err_cnt - d_err, 0);
    checkOutput("fill_full", board_full, 1);
    checkOutput("fill_last_addr", last_we_addr, 99);
    checkOutput("fill_last_data", last_we_data, 2);

    // A full board ignores further input.
    d_done = done_cnt; d_err = err_cnt; d_we = we_cnt;
    sendMove(0, 0);
    repeat (6) @(negedge CLOCK_50);
    checkOutput("full_done", done_cnt - d_done, 0);
    checkOutput("full_err", err_cnt - d_err, 0);
    checkOutput("full_we", we_cnt - d_we, 0);
    checkOutput("full_hold", board_full, 1);

`ifndef BOARD_CLEAR_EN
    checkOutput("we_single", we_run_max, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
